// File: rtl/pin_toggle_sequencer.sv
// Command-driven toggle sequencer for pin_controller: queues (pin, count, period)
// commands in a small FIFO and replays each as evenly spaced one-cycle toggle pulses.
module pin_toggle_sequencer #(
  parameter int NUM_PINS   = 64,
  parameter int IDX_W      = 6,
  parameter int CNT_W      = 8,
  parameter int PER_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [IDX_W-1:0]             cmd_pin,
  input  logic [CNT_W-1:0]             cmd_count,
  input  logic [PER_W-1:0]             cmd_period,
  input  logic                         abort,
  output logic [NUM_PINS-1:0]          toggle_mask,
  output logic                         toggle_enable,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [NUM_PINS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_PINS-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [IDX_W-1:0] pin_mem_r [FIFO_DEPTH];
  logic [CNT_W-1:0] cnt_mem_r [FIFO_DEPTH];
  logic [PER_W-1:0] per_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;

  state_t           state_r;
  logic [IDX_W-1:0] pin_r;
  logic [CNT_W-1:0] rem_r;
  logic [PER_W-1:0] per_r;
  logic [PER_W-1:0] timer_r;

  logic             push_s;
  logic             pop_s;
  logic [IDX_W-1:0] head_pin_s;
  logic [CNT_W-1:0] head_cnt_s;
  logic [PER_W-1:0] head_per_s;

  // Abort blocks acceptance in the same cycle, so a push never races the flush.
  assign cmd_ready  = !rst && !abort && (level_r < LVL_W'(FIFO_DEPTH));
  assign push_s     = cmd_valid && cmd_ready;
  assign pop_s      = (state_r == ST_IDLE) && (level_r != {LVL_W{1'b0}}) && !abort;
  assign head_pin_s = pin_mem_r[rd_ptr_r];
  assign head_cnt_s = cnt_mem_r[rd_ptr_r];
  assign head_per_s = (per_mem_r[rd_ptr_r] == {PER_W{1'b0}}) ? PER_W'(1) : per_mem_r[rd_ptr_r];
  assign busy       = (state_r != ST_IDLE) || (level_r != {LVL_W{1'b0}});
  assign fifo_level = level_r;

  // Command storage; contents are don't-care until pushed, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pin_mem_r[wr_ptr_r] <= cmd_pin;
      cnt_mem_r[wr_ptr_r] <= cmd_count;
      per_mem_r[wr_ptr_r] <= cmd_period;
    end
  end

  // FIFO pointers and occupancy, flushed by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (abort) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pin_r         <= {IDX_W{1'b0}};
      rem_r         <= {CNT_W{1'b0}};
      per_r         <= {PER_W{1'b0}};
      timer_r       <= {PER_W{1'b0}};
      toggle_enable <= 1'b0;
      toggle_mask   <= {NUM_PINS{1'b0}};
      done          <= 1'b0;
    end else begin
      toggle_enable <= 1'b0;
      toggle_mask   <= {NUM_PINS{1'b0}};
      done          <= 1'b0;
      if (abort) begin
        state_r <= ST_IDLE;
        rem_r   <= {CNT_W{1'b0}};
        timer_r <= {PER_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (pop_s) begin
              pin_r <= head_pin_s;
              rem_r <= head_cnt_s;
              per_r <= head_per_s;
              if (head_cnt_s != {CNT_W{1'b0}}) begin
                state_r       <= ST_PULSE;
                toggle_enable <= 1'b1;
                toggle_mask   <= onehot(head_pin_s);
              end else begin
                state_r <= ST_DONE;
                done    <= 1'b1;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_PULSE: begin
            rem_r <= rem_r - CNT_W'(1);
            if (rem_r == CNT_W'(1)) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end else if (per_r == PER_W'(1)) begin
              state_r       <= ST_PULSE;
              toggle_enable <= 1'b1;
              toggle_mask   <= onehot(pin_r);
            end else begin
              // WAIT spans per-1 cycles so pulse starts land exactly per apart.
              state_r <= ST_WAIT;
              timer_r <= per_r - PER_W'(2);
            end
          end
          ST_WAIT: begin
            if (timer_r == {PER_W{1'b0}}) begin
              state_r       <= ST_PULSE;
              toggle_enable <= 1'b1;
              toggle_mask   <= onehot(pin_r);
            end else begin
              timer_r <= timer_r - PER_W'(1);
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pin_toggle_sequencer.sv
// Scoreboard bench for pin_toggle_sequencer: each accepted command pushes its expected
// pulse/done events; a negedge monitor pops and checks kind, mask and cycle spacing.
module tb_pin_toggle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_pin;
  logic [7:0]  cmd_count;
  logic [15:0] cmd_period;
  logic        abort;
  logic [63:0] toggle_mask;
  logic        toggle_enable;
  logic        busy;
  logic        done;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_evt = 0;

  typedef struct {
    bit          is_done;
    logic [63:0] mask;
    bit          exact;
    int          gap;
    int          base;
  } exp_t;

  exp_t sb[$];

  pin_toggle_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_pin      (cmd_pin),
    .cmd_count    (cmd_count),
    .cmd_period   (cmd_period),
    .abort        (abort),
    .toggle_mask  (toggle_mask),
    .toggle_enable(toggle_enable),
    .busy         (busy),
    .done         (done),
    .fifo_level   (fifo_level)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: invariant plus scoreboard pop for every pulse or done cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (toggle_enable !== 1'b1 && toggle_mask !== 64'd0) begin
        errors++;
        $display("FAIL mask_without_enable: mask=%h, required 0 at cycle %0d", toggle_mask, cyc);
      end
      if (toggle_enable === 1'b1 || done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: enable=%0b done=%0b mask=%h at cycle %0d, none expected",
                   toggle_enable, done, toggle_mask, cyc);
        end else begin
          exp_t it;
          int   ref_c;
          it = sb.pop_front();
          ref_c = (it.base >= 0) ? it.base : last_evt;
          if (it.is_done) begin
            if (done !== 1'b1 || toggle_enable !== 1'b0) begin
              errors++;
              $display("FAIL event_kind: enable=%0b done=%0b, required done only", toggle_enable, done);
            end
          end else begin
            if (toggle_enable !== 1'b1 || done !== 1'b0 || toggle_mask !== it.mask) begin
              errors++;
              $display("FAIL pulse: enable=%0b done=%0b mask=%h, required enable only mask=%h",
                       toggle_enable, done, toggle_mask, it.mask);
            end
          end
          if (it.exact ? (cyc != ref_c + it.gap) : (cyc < ref_c + it.gap)) begin
            errors++;
            $display("FAIL event_timing: at cycle %0d, required %s %0d (done=%0b)",
                     cyc, it.exact ? "exactly" : "at least", ref_c + it.gap, it.is_done);
          end
          last_evt = cyc;
        end
      end
    end
  end

  task automatic send_cmd(input int pin, input int cnt, input int per,
                          input int budget, output int waited);
    bit acc;
    bit idle;
    exp_t it;
    int p;
    waited = 0;
    acc = 1'b0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_pin    = 6'(pin);
    cmd_count  = 8'(cnt);
    cmd_period = 16'(per);
    while (!acc && waited < budget) begin
      acc  = cmd_ready;
      idle = (sb.size() == 0) && (busy === 1'b0);
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: pin %0d not accepted after %0d cycles, required acceptance", pin, waited);
    end else begin
      p = (per == 0) ? 1 : per;
      for (int k = 0; k < cnt; k++) begin
        it.is_done = 1'b0;
        it.mask    = 64'd1 << pin;
        if (k == 0) begin
          it.exact = idle;
          it.gap   = idle ? 1 : 2;
          it.base  = idle ? cyc : -1;
        end else begin
          it.exact = 1'b1;
          it.gap   = p;
          it.base  = -1;
        end
        sb.push_back(it);
      end
      it.is_done = 1'b1;
      it.mask    = 64'd0;
      if (cnt == 0) begin
        it.exact = idle;
        it.gap   = idle ? 1 : 2;
        it.base  = idle ? cyc : -1;
      end else begin
        it.exact = 1'b1;
        it.gap   = 1;
        it.base  = -1;
      end
      sb.push_back(it);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%0b, required pending=0 busy=0", name, sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_pin = 6'd0; cmd_count = 8'd0; cmd_period = 16'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || toggle_enable !== 1'b0 || toggle_mask !== 64'd0 ||
        done !== 1'b0 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b en=%0b mask=%h done=%0b busy=%0b lvl=%0d, required all 0",
               cmd_ready, toggle_enable, toggle_mask, done, busy, fifo_level);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b lvl=%0d busy=%0b, required 1 0 0", cmd_ready, fifo_level, busy);
    end
  endtask

  task automatic test_single();
    int w;
    send_cmd(3, 2, 4, 10, w);
    wait_drain("single", 50);
  endtask

  task automatic test_back_to_back();
    int w;
    send_cmd(0, 3, 1, 10, w);
    send_cmd(63, 1, 0, 10, w);
    wait_drain("back_to_back", 50);
  endtask

  task automatic test_fifo_full();
    int w;
    send_cmd(5, 10, 8, 10, w);
    send_cmd(10, 2, 3, 10, w);
    send_cmd(20, 1, 1, 10, w);
    send_cmd(30, 3, 2, 10, w);
    send_cmd(40, 1, 0, 10, w);
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: lvl=%0d ready=%0b, required lvl=4 ready=0", fifo_level, cmd_ready);
    end
    send_cmd(50, 2, 5, 200, w);
    checks++;
    if (w == 0) begin
      errors++;
      $display("FAIL fifo_full_hold: fifth command waited %0d cycles, required >0", w);
    end
    wait_drain("fifo_full", 300);
  endtask

  task automatic test_count_zero();
    int w;
    send_cmd(1, 2, 3, 10, w);
    send_cmd(2, 0, 5, 10, w);
    send_cmd(4, 1, 2, 10, w);
    wait_drain("count_zero", 60);
  endtask

  task automatic test_abort();
    int w;
    int n = 0;
    send_cmd(7, 5, 6, 10, w);
    send_cmd(8, 1, 1, 10, w);
    send_cmd(11, 2, 2, 10, w);
    @(negedge clk);
    while (toggle_enable !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd2 || toggle_enable !== 1'b0) begin
      errors++;
      $display("FAIL abort_setup: lvl=%0d en=%0b, required lvl=2 en=0 (waiting)", fifo_level, toggle_enable);
    end
    abort = 1'b1;
    cmd_valid = 1'b1; cmd_pin = 6'd12; cmd_count = 8'd1; cmd_period = 16'd1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: ready=%0b, required 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    sb.delete();
    abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (toggle_enable !== 1'b0 || toggle_mask !== 64'd0 || fifo_level !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush: en=%0b mask=%h lvl=%0d busy=%0b done=%0b, required all 0",
               toggle_enable, toggle_mask, fifo_level, busy, done);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_dropped: lvl=%0d busy=%0b, required 0 0", fifo_level, busy);
    end
  endtask

  task automatic test_async_reset();
    int w;
    int n = 0;
    send_cmd(9, 4, 3, 10, w);
    @(negedge clk);
    while (toggle_enable !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (toggle_enable !== 1'b0 || toggle_mask !== 64'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%0b mask=%h done=%0b, required 0 without clock", toggle_enable, toggle_mask, done);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_fifo: lvl=%0d busy=%0b, required 0 0", fifo_level, busy);
    end
    rst = 1'b0;
    send_cmd(10, 1, 0, 10, w);
    wait_drain("after_reset", 30);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_count_zero();
    test_abort();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pin_toggle_sequencer.md
Name: pin_toggle_sequencer

Overview:
- Command-driven sequencer that drives the toggle_mask/toggle_enable inputs of the 64-bit pin_controller.
- Each queued command toggles one pin N times, with a programmable spacing in clocks between toggles.
- Sits between host/test logic and pin_controller. Buffers commands in a small FIFO and executes them strictly in order.

Parameters:
NUM_PINS, 64, width of toggle_mask; pin_controller output width
IDX_W, 6, pin index width (log2 NUM_PINS)
CNT_W, 8, toggle-count field width
PER_W, 16, toggle-period field width, in clocks
FIFO_DEPTH, 4, command FIFO entries (power of 2)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; a command transfers on a rising edge with cmd_valid&&cmd_ready
cmd_pin  in  IDX_W  pin index to toggle
cmd_count  in  CNT_W  number of toggle pulses
cmd_period  in  PER_W  clocks between successive pulse starts
abort  in  1  synchronous flush/stop
toggle_mask  out  NUM_PINS  to pin_controller; one-hot (1<<pin) during a pulse, else 0
toggle_enable  out  1  to pin_controller; high exactly in PULSE state
busy  out  1  state!=IDLE or FIFO non-empty
done  out  1  one-cycle pulse at completion of each command
fifo_level  out  log2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, FIFO empty.
  - toggle_mask=0, toggle_enable=0, done=0, busy=0, fifo_level=0.
  - cmd_ready=0 while rst is high.
- FIFO:
  - cmd_ready = (fifo_level<FIFO_DEPTH) && !abort.
  - No write-through when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, PULSE, WAIT, DONE. Outputs are decoded from registered state and latched fields.
- IDLE:
  - If FIFO non-empty, pop the head and latch pin, count into rem, and max(period,1) into per.
  - Go to PULSE if count!=0, else DONE.
- PULSE:
  - toggle_enable=1, toggle_mask=1<<pin for this one cycle; rem decrements.
  - If rem==1: next state DONE.
  - Else if per==1: stay in PULSE (enable held high for consecutive cycles).
  - Else: go to WAIT with timer=per-2.
- WAIT:
  - toggle_enable=0, mask=0.
  - If timer==0 go to PULSE, else timer decrements.
  - Spacing between pulse starts is exactly per cycles.
- DONE:
  - done=1 for one cycle, then IDLE.
  - Next command's first pulse starts no earlier than 2 cycles after DONE.
- Latency:
  - Command accepted on edge E while IDLE and FIFO empty: popped at E+1, toggle_enable high in the cycle after E+1.
- count==0: no pulses; done still pulses once.
- period==0 is treated as 1.
- abort (sampled on clock edge):
  - FIFO flushed, state to IDLE, rem/timer cleared.
  - toggle_enable=0 and mask=0 from the next cycle; no done pulse.
  - A command offered in the same cycle is not accepted.
  - abort takes priority over every other event.
- Reset mid-command: outputs drop to 0 immediately (async); the command is lost.
- pin index is always within 0..NUM_PINS-1 (full IDX_W range legal); mask is strictly one-hot or zero.
- Invariant: toggle_enable==0 implies toggle_mask==0.

Test Plan:
- Single command: pin=3, count=2, period=4 -> enable high 2 single cycles, starts 4 cycles apart; mask=0x8 on both; pin_controller bit 3 returns to 0; one done pulse 1 cycle after the last pulse.
- Back-to-back, period<=1: pin=0, count=3, period=1 -> enable high 3 consecutive cycles with mask=0x1; then pin=63, count=1, period=0 -> single pulse with mask=0x8000_0000_0000_0000; two done pulses in order.
- FIFO full: push 5 commands without gaps while the sequencer runs a count=10, period=8 command -> cmd_ready low once fifo_level=4; the 5th command is held until a pop; all commands execute in FIFO order.
- count==0 command between two valid commands -> no toggle_enable for it; done pulses 3 times total; order preserved.
- Abort during WAIT with 2 queued commands -> next cycle toggle_enable=0, fifo_level=0, busy=0, no done; a cmd_valid in the abort cycle is dropped.
- Async reset asserted mid-PULSE -> toggle_enable/mask=0 without waiting for a clock edge; after release the FIFO is empty; a new command runs with the 2-cycle latency.
